// File: rtl/mem_seq_pkg.sv
// Shared definitions for the asynchronous memory access sequencer.
// Holds the FSM state type, the default strobe timing (in clock cycles),
// the phase counter width and a helper that turns a cycle count into
// the value loaded into the down-counter.
package mem_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_RAM_RD_CYC = 5;
  localparam int DEF_ROM_RD_CYC = 8;
  localparam int DEF_WR_CYC     = 5;
  localparam int DEF_HOLD_CYC   = 1;

  // A phase of N cycles loads N-1 and ends when the counter reads zero.
  // A requested length of 0 is stretched to a single cycle.
  function automatic logic [CNT_W-1:0] cyc_to_load(input int cyc);
    if (cyc <= 32'sd1) begin
      cyc_to_load = {CNT_W{1'b0}};
    end else begin
      cyc_to_load = CNT_W'(cyc - 32'sd1);
    end
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Phase down-counter for the memory access sequencer.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   load          - load load_value (takes priority over decrement)
//   load_value    - cycles remaining in the new phase minus one
//   decrement     - count down by one (saturates at zero)
//   done          - counter is zero: current cycle is the last of the phase
module mem_wait_counter
  import mem_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             decrement,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Count register: reset, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != {CNT_W{1'b0}})) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign done = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequencer for a shared asynchronous RAM/ROM bus (PSRAM in async mode plus
// parallel flash). One request at a time is latched and played out as
// SETUP -> ACTIVE -> HOLD -> RESP with programmable cycle counts.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_ready         - request handshake (accept when both 1)
//   req_write, req_chip         - 1=write / 0=read, 0=RAM / 1=ROM
//   req_addr, req_wdata, req_be - word address, write data, byte enables
//   rsp_valid, rsp_rdata, rsp_err - completion pulse, read data, reject flag
//   mem_addr, mem_data          - memory address bus, bidirectional data bus
//   mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n - shared active-low strobes
//   mt_ce_n, st_ce_n            - RAM / ROM chip enables (active low)
//   mt_clk, mt_adv_n, mt_cre    - RAM sync-mode pins, tied low
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDRESS_SIZE = 24,
  parameter int DATA_SIZE    = 16,
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int RAM_RD_CYC   = DEF_RAM_RD_CYC,
  parameter int ROM_RD_CYC   = DEF_ROM_RD_CYC,
  parameter int WR_CYC       = DEF_WR_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_chip,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]    req_wdata,
  input  logic [1:0]              req_be,
  output logic                    rsp_valid,
  output logic [DATA_SIZE-1:0]    rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  inout  wire  [DATA_SIZE-1:0]    mem_data,
  output logic                    mem_oe_n,
  output logic                    mem_we_n,
  output logic                    mem_lb_n,
  output logic                    mem_ub_n,
  output logic                    mt_ce_n,
  output logic                    st_ce_n,
  output logic                    mt_clk,
  output logic                    mt_adv_n,
  output logic                    mt_cre
);

  localparam logic [CNT_W-1:0] SETUP_LD  = cyc_to_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] RAM_RD_LD = cyc_to_load(RAM_RD_CYC);
  localparam logic [CNT_W-1:0] ROM_RD_LD = cyc_to_load(ROM_RD_CYC);
  localparam logic [CNT_W-1:0] WR_LD     = cyc_to_load(WR_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD   = cyc_to_load(HOLD_CYC);

  state_t state, next_state;

  // Request fields captured at acceptance.
  logic                    lat_write, lat_chip, lat_reject;
  logic [ADDRESS_SIZE-1:0] lat_addr;
  logic [DATA_SIZE-1:0]    lat_wdata;
  logic [1:0]              lat_be;

  // Value the latched fields will hold after the coming edge.
  logic                    write_nxt, chip_nxt, reject_nxt;
  logic [ADDRESS_SIZE-1:0] addr_nxt;
  logic [1:0]              be_nxt;

  logic             accept, req_reject;
  logic             reject_pend, reject_pend_nxt;
  logic             cnt_load, cnt_dec, cnt_done;
  logic [CNT_W-1:0] cnt_load_value;
  logic             dq_drive;

  // Registered-output next values.
  logic                    in_access_nxt;
  logic                    ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [ADDRESS_SIZE-1:0] mem_addr_nxt;
  logic                    oe_n_nxt, we_n_nxt, lb_n_nxt, ub_n_nxt;
  logic                    mt_ce_n_nxt, st_ce_n_nxt, dq_drive_nxt;

  assign accept     = req_valid & req_ready;
  assign req_reject = req_write & req_chip;

  mem_wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .decrement  (cnt_dec),
    .done       (cnt_done)
  );

  // Next-state and phase counter control.
  always_comb begin
    next_state      = state;
    cnt_load        = 1'b0;
    cnt_load_value  = {CNT_W{1'b0}};
    cnt_dec         = 1'b0;
    reject_pend_nxt = 1'b0;
    case (state)
      // RESP also accepts so back-to-back requests lose no cycle.
      ST_IDLE, ST_RESP: begin
        if (reject_pend) begin
          next_state = ST_RESP;
        end else if (accept) begin
          if (req_reject) begin
            // A rejected ROM write sits one cycle in IDLE (not ready),
            // then reports; it never touches the bus.
            next_state      = ST_IDLE;
            reject_pend_nxt = 1'b1;
          end else begin
            next_state     = ST_SETUP;
            cnt_load       = 1'b1;
            cnt_load_value = SETUP_LD;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          next_state = ST_ACTIVE;
          cnt_load   = 1'b1;
          if (lat_write) begin
            cnt_load_value = WR_LD;
          end else if (lat_chip) begin
            cnt_load_value = ROM_RD_LD;
          end else begin
            cnt_load_value = RAM_RD_LD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (cnt_done) begin
          next_state     = ST_HOLD;
          cnt_load       = 1'b1;
          cnt_load_value = HOLD_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          next_state = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Latched-field next values; byte enables 00 mean "both bytes".
  always_comb begin
    write_nxt  = lat_write;
    chip_nxt   = lat_chip;
    reject_nxt = lat_reject;
    addr_nxt   = lat_addr;
    be_nxt     = lat_be;
    if (accept) begin
      write_nxt  = req_write;
      chip_nxt   = req_chip;
      reject_nxt = req_reject;
      addr_nxt   = req_addr;
      be_nxt     = (req_be == 2'b00) ? 2'b11 : req_be;
    end else begin
      write_nxt  = lat_write;
      chip_nxt   = lat_chip;
      reject_nxt = lat_reject;
      addr_nxt   = lat_addr;
      be_nxt     = lat_be;
    end
  end

  // Output next values decoded from the next state, so every registered
  // pin changes on the same edge as the state it belongs to.
  always_comb begin
    in_access_nxt = (next_state == ST_SETUP) || (next_state == ST_ACTIVE) ||
                    (next_state == ST_HOLD);
    ready_nxt     = ((next_state == ST_IDLE) && !reject_pend_nxt) ||
                    (next_state == ST_RESP);
    rsp_valid_nxt = (next_state == ST_RESP);
    rsp_err_nxt   = (next_state == ST_RESP) && reject_nxt;
    mem_addr_nxt  = in_access_nxt ? addr_nxt : {ADDRESS_SIZE{1'b0}};
    mt_ce_n_nxt   = !(in_access_nxt && !chip_nxt);
    st_ce_n_nxt   = !(in_access_nxt && chip_nxt);
    oe_n_nxt      = !((next_state == ST_ACTIVE) && !write_nxt);
    we_n_nxt      = !((next_state == ST_ACTIVE) && write_nxt);
    lb_n_nxt      = in_access_nxt ? !be_nxt[0] : 1'b1;
    ub_n_nxt      = in_access_nxt ? !be_nxt[1] : 1'b1;
    dq_drive_nxt  = in_access_nxt && write_nxt;
  end

  // State, latched request and registered bus/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      reject_pend <= 1'b0;
      lat_write   <= 1'b0;
      lat_chip    <= 1'b0;
      lat_reject  <= 1'b0;
      lat_addr    <= {ADDRESS_SIZE{1'b0}};
      lat_wdata   <= {DATA_SIZE{1'b0}};
      lat_be      <= 2'b11;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= {DATA_SIZE{1'b0}};
      mem_addr    <= {ADDRESS_SIZE{1'b0}};
      mem_oe_n    <= 1'b1;
      mem_we_n    <= 1'b1;
      mem_lb_n    <= 1'b1;
      mem_ub_n    <= 1'b1;
      mt_ce_n     <= 1'b1;
      st_ce_n     <= 1'b1;
      dq_drive    <= 1'b0;
    end else begin
      state       <= next_state;
      reject_pend <= reject_pend_nxt;
      lat_write   <= write_nxt;
      lat_chip    <= chip_nxt;
      lat_reject  <= reject_nxt;
      lat_addr    <= addr_nxt;
      lat_wdata   <= accept ? req_wdata : lat_wdata;
      lat_be      <= be_nxt;
      req_ready   <= ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_err     <= rsp_err_nxt;
      // Read data is sampled while OE is still low on the last ACTIVE cycle.
      if ((state == ST_ACTIVE) && cnt_done && !lat_write) begin
        rsp_rdata <= mem_data;
      end else begin
        rsp_rdata <= rsp_rdata;
      end
      mem_addr    <= mem_addr_nxt;
      mem_oe_n    <= oe_n_nxt;
      mem_we_n    <= we_n_nxt;
      mem_lb_n    <= lb_n_nxt;
      mem_ub_n    <= ub_n_nxt;
      mt_ce_n     <= mt_ce_n_nxt;
      st_ce_n     <= st_ce_n_nxt;
      dq_drive    <= dq_drive_nxt;
    end
  end

  assign mem_data = dq_drive ? lat_wdata : {DATA_SIZE{1'bz}};

  // RAM runs in asynchronous mode: its synchronous-interface pins stay low.
  assign mt_clk   = 1'b0;
  assign mt_adv_n = 1'b0;
  assign mt_cre   = 1'b0;

endmodule
